tholin_mux_display_decoder: RTL

Receive-side monitor for the multiplexed two-digit 7-segment output bus: it watches the 7 segment lines and the digit-select line, waits for each multiplexed phase to settle, and decodes the segment patterns back to hex nibbles. It assembles each low/high digit pair into an 8-bit value. It is used in test harnesses and on-board self-check, downstream of any block driving the `dout[6:0]`/`SEL` display bus. It also flags illegal segment patterns and a stalled multiplex.

---
 rtl/tholin_mux_display_decoder.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/tholin_mux_display_decoder.sv
// rtl/tholin_mux_display_decoder.sv - monitor that decodes a multiplexed two-digit 7-segment bus back to bytes
module tholin_mux_display_decoder #(
    parameter int SETTLE  = 2,
    parameter int TIMEOUT = 1024
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [6:0] seg_in,
    input  logic       sel_in,
    output logic [7:0] value,
    output logic       value_valid,
    output logic       digit_err,
    output logic       stalled,
    output logic [7:0] frame_cnt
);

    localparam logic [1:0] ST_SYNC   = 2'd0;
    localparam logic [1:0] ST_SETTLE = 2'd1;
    localparam logic [1:0] ST_HOLD   = 2'd2;

    localparam logic [3:0]  SETTLE_C  = 4'(SETTLE);
    localparam logic [15:0] TIMEOUT_C = 16'(TIMEOUT);

    logic [6:0]  seg_r, seg_p;
    logic        sel_r, sel_p;
    logic [3:0]  cnt;
    logic [15:0] idle;
    logic [1:0]  state;
    logic [3:0]  lo_q, hi_q;
    logic        have_lo, have_hi;

    logic        chg, seg_stable, timeout_hit, take;
    logic        dec_ok;
    logic [3:0]  dec_nib;

    assign chg         = (sel_r != sel_p);
    assign seg_stable  = (seg_r == seg_p);
    assign timeout_hit = !chg && (idle == TIMEOUT_C);
    // A phase that ends exactly as cnt saturates is dropped rather than sampled with the next SEL.
    assign take        = (state == ST_SETTLE) && !chg && seg_stable &&
                         (cnt == SETTLE_C) && !timeout_hit;

    always_comb begin
        dec_ok  = 1'b1;
        dec_nib = 4'h0;
        case (seg_r)
            7'h3F: dec_nib = 4'h0;
            7'h06: dec_nib = 4'h1;
            7'h5B: dec_nib = 4'h2;
            7'h4F: dec_nib = 4'h3;
            7'h66: dec_nib = 4'h4;
            7'h6D: dec_nib = 4'h5;
            7'h7D: dec_nib = 4'h6;
            7'h07: dec_nib = 4'h7;
            7'h7F: dec_nib = 4'h8;
            7'h6F: dec_nib = 4'h9;
            7'h77: dec_nib = 4'hA;
            7'h7C: dec_nib = 4'hB;
            7'h39: dec_nib = 4'hC;
            7'h5E: dec_nib = 4'hD;
            7'h79: dec_nib = 4'hE;
            7'h71: dec_nib = 4'hF;
            default: dec_ok = 1'b0;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            // Input stage tracks the pins so the phase in flight at reset yields no chg.
            seg_r       <= seg_in;
            sel_r       <= sel_in;
            seg_p       <= seg_in;
            sel_p       <= sel_in;
            cnt         <= 4'd0;
            idle        <= 16'd0;
            state       <= ST_SYNC;
            lo_q        <= 4'h0;
            hi_q        <= 4'h0;
            have_lo     <= 1'b0;
            have_hi     <= 1'b0;
            value       <= 8'h00;
            value_valid <= 1'b0;
            digit_err   <= 1'b0;
            stalled     <= 1'b0;
            frame_cnt   <= 8'h00;
        end else begin
            seg_r       <= seg_in;
            sel_r       <= sel_in;
            seg_p       <= seg_r;
            sel_p       <= sel_r;
            value_valid <= 1'b0;
            digit_err   <= 1'b0;

            if (chg || !seg_stable)
                cnt <= 4'd0;
            else if (cnt != SETTLE_C)
                cnt <= cnt + 4'd1;

            if (chg)
                idle <= 16'd0;
            else if (idle != 16'hFFFF)
                idle <= idle + 16'd1;

            if (chg)
                stalled <= 1'b0;
            else if (timeout_hit)
                stalled <= 1'b1;

            if (timeout_hit) begin
                state   <= ST_SYNC;
                have_lo <= 1'b0;
                have_hi <= 1'b0;
            end else if (chg) begin
                // The first toggle out of a stall only clears it; the phase it opens is discarded.
                if (state != ST_SYNC || !stalled)
                    state <= ST_SETTLE;
            end else if (take) begin
                state <= ST_HOLD;
                if (!dec_ok) begin
                    digit_err <= 1'b1;
                    have_lo   <= 1'b0;
                    have_hi   <= 1'b0;
                end else if (sel_r) begin
                    hi_q <= dec_nib;
                    if (have_lo) begin
                        value       <= {dec_nib, lo_q};
                        value_valid <= 1'b1;
                        frame_cnt   <= frame_cnt + 8'd1;
                        have_lo     <= 1'b0;
                        have_hi     <= 1'b0;
                    end else begin
                        have_hi <= 1'b1;
                    end
                end else begin
                    lo_q <= dec_nib;
                    if (have_hi) begin
                        value       <= {hi_q, dec_nib};
                        value_valid <= 1'b1;
                        frame_cnt   <= frame_cnt + 8'd1;
                        have_lo     <= 1'b0;
                        have_hi     <= 1'b0;
                    end else begin
                        have_lo <= 1'b1;
                    end
                end
            end
        end
    end

endmodule
